// File: rtl/sdram_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module   : sdram_bridge_pkg
// Brief    : Shared state encoding and constants for the SDRAM Wishbone bridge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sdram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam int unsigned TMO_DEFAULT = 255;
  localparam logic [1:0]  DQM_READ    = 2'b00;

endpackage

`default_nettype wire

// File: rtl/sdram_req_wdog.sv
//------------------------------------------------------------------------------
// Module   : sdram_req_wdog
// Brief    : 8-bit request watchdog; counts enabled cycles and flags the limit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_req_wdog #(
  parameter int unsigned TMO = 255
) (
  input  logic clk_p,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TMO);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/sdram_wb_bridge.sv
//------------------------------------------------------------------------------
// Module   : sdram_wb_bridge
// Brief    : Wishbone-classic CPU bus to sdram_top req/ack bridge with watchdog.
//            Optional macro SDRAM_WPOST_EN enables a one-entry posted write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned AW  = 21,
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic          clk_p,
  input  logic          rst_n,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [1:0]    wb_sel,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack,
  input  logic          ctl_init_done,
  output logic          ctl_wr_req,
  output logic          ctl_rd_req,
  input  logic          ctl_wr_ack,
  input  logic          ctl_rd_ack,
  output logic [AW:0]   ctl_adr,
  output logic [DW-1:0] ctl_dat_o,
  input  logic [DW-1:0] ctl_dat_i,
  output logic [1:0]    dqm,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [1:0]    dqm_q, dqm_d;
  logic          we_q, we_d;
  logic          wr_req_q, wr_req_d;
  logic          rd_req_q, rd_req_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          post_busy;
  logic          wd_clr, wd_en, wd_expired;
  logic          ack_match;

`ifdef SDRAM_WPOST_EN
  logic post_q, post_d;
  assign post_busy = post_q;
`else
  assign post_busy = 1'b0;
`endif

  assign ack_match = we_q ? ctl_wr_ack : ctl_rd_ack;

  sdram_req_wdog #(.TMO(TMO)) u_wdog (
    .clk_p    (clk_p),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    dqm_d    = dqm_q;
    we_d     = we_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    ack_d    = ack_q;
    err_d    = err_q;
    wd_clr   = 1'b1;
    wd_en    = 1'b0;
`ifdef SDRAM_WPOST_EN
    post_d   = post_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wb_stb && ctl_init_done && !post_busy) begin
          adr_d = wb_adr;
          dat_d = wb_dat_i;
          we_d  = wb_we;
          dqm_d = wb_we ? ~wb_sel : DQM_READ;
`ifdef SDRAM_WPOST_EN
          // Posted write: ack the CPU now, the buffer drives the controller.
          if (wb_we) begin
            post_d   = 1'b1;
            wr_req_d = 1'b1;
            ack_d    = 1'b1;
            state_d  = ST_ACK;
          end else begin
            rd_req_d = 1'b1;
            state_d  = ST_REQ;
          end
`else
          wr_req_d = wb_we;
          rd_req_d = !wb_we;
          state_d  = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        wd_clr = 1'b0;
        wd_en  = 1'b1;
        if (ack_match) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!we_q) rdat_d = ctl_dat_i;
          ack_d   = wb_stb;
          state_d = wb_stb ? ST_ACK : ST_IDLE;
        end else if (wd_expired) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          err_d    = 1'b1;
          if (!we_q) rdat_d = '1;
          state_d  = ST_TMO;
        end
      end
      ST_TMO: begin
        ack_d   = wb_stb;
        state_d = wb_stb ? ST_ACK : ST_IDLE;
      end
      ST_ACK: begin
        if (!wb_stb) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SDRAM_WPOST_EN
    if (post_q) begin
      wd_clr = 1'b0;
      wd_en  = 1'b1;
      if (ctl_wr_ack) begin
        post_d   = 1'b0;
        wr_req_d = 1'b0;
      end else if (wd_expired) begin
        post_d   = 1'b0;
        wr_req_d = 1'b0;
        err_d    = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      rdat_q   <= '0;
      dqm_q    <= 2'b00;
      we_q     <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef SDRAM_WPOST_EN
      post_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      dqm_q    <= dqm_d;
      we_q     <= we_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
`ifdef SDRAM_WPOST_EN
      post_q   <= post_d;
`endif
    end
  end

  // Combinational AND so the ack falls in the same cycle the strobe does.
  assign wb_ack     = wb_stb & ack_q;
  assign wb_dat_o   = rdat_q;
  assign ctl_wr_req = wr_req_q;
  assign ctl_rd_req = rd_req_q;
  assign ctl_adr    = {1'b0, adr_q};
  assign ctl_dat_o  = dat_q;
  assign dqm        = dqm_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_wb_bridge.sv
//------------------------------------------------------------------------------
// Module   : tb_sdram_wb_bridge
// Brief    : Directed table-driven bench for sdram_wb_bridge (SDRAM_WPOST_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_wb_bridge;

  logic        clk_p = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [20:0] wb_adr = '0;
  logic [15:0] wb_dat_i = '0, wb_dat_o;
  logic        wb_ack;
  logic        ctl_init_done = 1'b1;
  logic        ctl_wr_req, ctl_rd_req;
  logic        ctl_wr_ack = 1'b0, ctl_rd_ack = 1'b0;
  logic [21:0] ctl_adr;
  logic [15:0] ctl_dat_o;
  logic [15:0] ctl_dat_i = 16'hDEAD;
  logic [1:0]  dqm;
  logic        err;

  sdram_wb_bridge dut (
    .clk_p(clk_p), .rst_n(rst_n), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .ctl_init_done(ctl_init_done), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
    .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_adr(ctl_adr),
    .ctl_dat_o(ctl_dat_o), .ctl_dat_i(ctl_dat_i), .dqm(dqm), .err(err)
  );

  always #5 clk_p = ~clk_p;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] wdat;
    int          dly;
    logic [15:0] rdat;
    logic        bogus;
    logic [1:0]  exp_dqm;
    logic [15:0] exp_dat_o;
  } vec_t;

  vec_t vecs[5];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int drops;
    wb_we    = v.we;
    wb_sel   = v.sel;
    wb_adr   = v.adr;
    wb_dat_i = v.wdat;
    wb_stb   = 1'b1;
`ifdef SDRAM_WPOST_EN
    if (v.we) begin
      step();
      chk("post_ack", 64'(wb_ack), 64'd1);
      chk("post_wr_req", 64'(ctl_wr_req), 64'd1);
      chk("post_dqm", 64'(dqm), 64'(v.exp_dqm));
      chk("post_dat", 64'(ctl_dat_o), 64'(v.wdat));
      wb_stb = 1'b0;
      for (int k = 1; k < v.dly; k++) step();
      ctl_wr_ack = 1'b1;
      step();
      ctl_wr_ack = 1'b0;
      chk("post_wr_drop", 64'(ctl_wr_req), 64'd0);
      chk("post_dat_o", 64'(wb_dat_o), 64'(v.exp_dat_o));
      step();
      return;
    end
`endif
    step();
    chk("req_wr", 64'(ctl_wr_req), 64'(v.we));
    chk("req_rd", 64'(ctl_rd_req), 64'(!v.we));
    chk("ctl_adr", 64'(ctl_adr), 64'({1'b0, v.adr}));
    chk("dqm", 64'(dqm), 64'(v.exp_dqm));
    chk("ctl_dat_o", 64'(ctl_dat_o), 64'(v.wdat));
    if (v.bogus) begin
      // wrong-direction ack must not end the request
      ctl_wr_ack = !v.we;
      ctl_rd_ack = v.we;
      step();
      ctl_wr_ack = 1'b0;
      ctl_rd_ack = 1'b0;
      chk("bogus_ignored", 64'({ctl_wr_req, ctl_rd_req, wb_ack}), 64'({v.we, !v.we, 1'b0}));
    end
    drops = 0;
    for (int k = 1; k < v.dly; k++) begin
      step();
      if ((ctl_wr_req | ctl_rd_req) !== 1'b1 || wb_ack !== 1'b0) drops++;
    end
    chk("req_held", 64'(drops), 64'd0);
    ctl_wr_ack = v.we;
    ctl_rd_ack = !v.we;
    ctl_dat_i  = v.rdat;
    step();
    ctl_wr_ack = 1'b0;
    ctl_rd_ack = 1'b0;
    ctl_dat_i  = 16'hDEAD;
    chk("req_dropped", 64'({ctl_wr_req, ctl_rd_req}), 64'd0);
    chk("wb_ack_n1", 64'(wb_ack), 64'd1);
    chk("wb_dat_o", 64'(wb_dat_o), 64'(v.exp_dat_o));
    step();
    step();
    chk("ack_hold", 64'({wb_ack, dqm, wb_dat_o}), 64'({1'b1, v.exp_dqm, v.exp_dat_o}));
    wb_stb = 1'b0;
    #1;
    chk("ack_drop_comb", 64'(wb_ack), 64'd0);
    step();
  endtask

  initial begin
    int bad, cyc, req_cyc;
    //          we    sel    adr        wdat      dly rdat      bogus dqm    dat_o
    vecs[0] = '{1'b0, 2'b11, 21'h000123, 16'h0000, 6, 16'hA5C3, 1'b0, 2'b00, 16'hA5C3};
    vecs[1] = '{1'b1, 2'b01, 21'h000456, 16'h1234, 3, 16'h0000, 1'b0, 2'b10, 16'hA5C3};
    vecs[2] = '{1'b1, 2'b00, 21'h1FFFFF, 16'hCAFE, 1, 16'h0000, 1'b0, 2'b11, 16'hA5C3};
    vecs[3] = '{1'b0, 2'b10, 21'h0AAAAA, 16'h7777, 1, 16'h5A5A, 1'b1, 2'b00, 16'h5A5A};
    vecs[4] = '{1'b1, 2'b11, 21'h155555, 16'h8001, 2, 16'h0000, 1'b1, 2'b00, 16'h5A5A};

    step();
    chk("reset_outputs",
        64'({wb_ack, ctl_wr_req, ctl_rd_req, err, dqm, ctl_adr, ctl_dat_o, wb_dat_o}), 64'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // strobe held while the controller is still initialising
    ctl_init_done = 1'b0;
    wb_we = 1'b0; wb_adr = 21'h000321; wb_stb = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (ctl_rd_req || ctl_wr_req || wb_ack) bad++;
    end
    chk("init_gate", 64'(bad), 64'd0);
    ctl_init_done = 1'b1;
    run_vec(vecs[0]);

    // strobe withdrawn during REQ: controller completes, no CPU ack
    wb_we = 1'b0; wb_adr = 21'h000005; wb_stb = 1'b1;
    step();
    chk("drop_req", 64'(ctl_rd_req), 64'd1);
    wb_stb = 1'b0;
    step();
    step();
    ctl_rd_ack = 1'b1; ctl_dat_i = 16'hBEEF;
    step();
    ctl_rd_ack = 1'b0; ctl_dat_i = 16'hDEAD;
    chk("drop_done", 64'({wb_ack, ctl_rd_req, wb_dat_o}), 64'({1'b0, 1'b0, 16'hBEEF}));
    wb_stb = 1'b1; wb_adr = 21'h000123;
    #1;
    chk("drop_no_stale_ack", 64'(wb_ack), 64'd0);
    run_vec(vecs[0]);

    // controller never answers
    wb_we = 1'b0; wb_adr = 21'h000777; wb_stb = 1'b1;
    req_cyc = 0;
    cyc = 0;
    do begin
      step();
      cyc++;
      if (ctl_rd_req) req_cyc++;
    end while (!wb_ack && cyc < 400);
    chk("tmo_ack", 64'(wb_ack), 64'd1);
    chk("tmo_req_cycles_ok", 64'(req_cyc >= 255 && req_cyc <= 256), 64'd1);
    chk("tmo_state", 64'({err, ctl_rd_req, wb_dat_o}), 64'({1'b1, 1'b0, 16'hFFFF}));
    wb_stb = 1'b0;
    step();
    run_vec(vecs[3]);
    chk("err_sticky", 64'(err), 64'd1);

    // asynchronous reset in the middle of a request
    wb_we = 1'b0; wb_adr = 21'h000999; wb_stb = 1'b1;
    step();
    chk("rst_pre_req", 64'(ctl_rd_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({ctl_rd_req, ctl_wr_req, wb_ack, err}), 64'd0);
    wb_stb = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_idle", 64'({ctl_rd_req, ctl_wr_req, wb_ack, ctl_adr}), 64'd0);
    run_vec(vecs[0]);

`ifdef SDRAM_WPOST_EN
    // posted write followed directly by a read
    wb_we = 1'b1; wb_sel = 2'b11; wb_adr = 21'h000040; wb_dat_i = 16'h4242; wb_stb = 1'b1;
    step();
    chk("pw_ack2", 64'({wb_ack, ctl_wr_req}), 64'({1'b1, 1'b1}));
    wb_stb = 1'b0;
    step();
    wb_we = 1'b0; wb_adr = 21'h000041; wb_stb = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (ctl_rd_req || wb_ack) bad++;
    end
    chk("pw_read_blocked", 64'(bad), 64'd0);
    ctl_wr_ack = 1'b1;
    step();
    ctl_wr_ack = 1'b0;
    chk("pw_wr_done", 64'({ctl_wr_req, ctl_rd_req}), 64'd0);
    step();
    chk("pw_read_issued", 64'({ctl_rd_req, ctl_adr}), 64'({1'b1, 22'h000041}));
    ctl_rd_ack = 1'b1; ctl_dat_i = 16'h0F0F;
    step();
    ctl_rd_ack = 1'b0;
    chk("pw_read_data", 64'({wb_ack, wb_dat_o}), 64'({1'b1, 16'h0F0F}));
    wb_stb = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
